// File: rtl/seq_mul4_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
// Optional zero flag on the multiplier is enabled with MUL_ZERO_FLAG_EN.
package seq_mul4_pkg;

    localparam int MUL_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mul_state_t;

    // Smallest n with 2**n > w, so a counter of n bits can reach w.
    function automatic int mulCntW(input int w);
        int n;
        n = 1;
        while ((1 << n) <= w) begin
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/mul_add4.sv
// Combinational WIDTH-bit carry adder shared by every multiply iteration.
// Carry-out is exposed so the accumulator never loses its top bit.
module mul_add4 #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign sum   = total[WIDTH-1:0];
    assign cout  = total[WIDTH];

endmodule

// File: rtl/seq_mul4.sv
// Multi-cycle unsigned shift-and-add multiplier with start/done handshake.
// Define MUL_ZERO_FLAG_EN to add the registered zero output.
module seq_mul4
    import seq_mul4_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEF,
    parameter int CNT_W = mulCntW(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
`ifdef MUL_ZERO_FLAG_EN
    ,
    output logic               zero
`endif
);

    mul_state_t state;
    mul_state_t stateNext;

    logic [WIDTH-1:0]   m;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   q;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   addB;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic               lastIter;
    logic [2*WIDTH-1:0] finalProd;

    assign addB      = q[0] ? m : '0;
    assign lastIter  = (count == CNT_W'(WIDTH - 1));
    // The shifted {c,S,Q} after the last iteration is the full product.
    assign finalProd = {cout, sum, q[WIDTH-1:1]};

    mul_add4 #(
        .WIDTH(WIDTH)
    ) uAdd (
        .a   (acc),
        .b   (addB),
        .cin (1'b0),
        .sum (sum),
        .cout(cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (lastIter) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign ready = (state == IDLE);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            m       <= '0;
            acc     <= '0;
            q       <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m     <= a;
                        q     <= b;
                        acc   <= '0;
                        count <= '0;
                    end
                end
                RUN: begin
                    acc   <= {cout, sum[WIDTH-1:1]};
                    q     <= {sum[0], q[WIDTH-1:1]};
                    count <= count + 1'b1;
                    if (lastIter) begin
                        product <= finalProd;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MUL_ZERO_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            zero <= 1'b1;
        end else if (state == RUN && lastIter) begin
            zero <= (finalProd == '0);
        end
    end
`endif

endmodule

// File: tb/tb_seq_mul4.sv
// Self-checking bench for seq_mul4: directed scenarios plus random
// operands checked against plain a*b arithmetic and a fixed latency.
module tb_seq_mul4;

    localparam int W   = 4;
    localparam int LAT = W + 1;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           ready;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
`ifdef MUL_ZERO_FLAG_EN
    logic           zero;
`endif

    int cmpCount;
    int errCount;
    int cyc;

    seq_mul4 #(
        .WIDTH(W),
        .CNT_W(3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .product(product)
`ifdef MUL_ZERO_FLAG_EN
        ,
        .zero   (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic runOp(
        input  logic [W-1:0]   ai,
        input  logic [W-1:0]   bi,
        input  bit             holdStart,
        output int             lat,
        output bit             busyBad,
        output logic [2*W-1:0] pStale,
        output logic [2*W-1:0] p,
        output logic           z,
        output int             doneCyc,
        output bit             tmo
    );
        int w;
        tmo     = 1'b0;
        busyBad = 1'b0;
        lat     = 0;
        z       = 1'b0;
        w       = 0;
        doneCyc = 0;
        pStale  = '0;
        p       = '0;
        while (!ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!ready) begin
            tmo = 1'b1;
            return;
        end
        a     = ai;
        b     = bi;
        start = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                pStale = product;
                if (holdStart) begin
                    a = 4'h2;
                    b = 4'h2;
                end else begin
                    start = 1'b0;
                end
            end
            if (!done && !busy) busyBad = 1'b1;
        end while (!done && lat < 30);
        start   = 1'b0;
        tmo     = !done;
        p       = product;
        doneCyc = cyc;
`ifdef MUL_ZERO_FLAG_EN
        z = zero;
`endif
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        cmpCount++;
        if ({ready, busy, done} !== 3'b100) begin
            errCount++;
            $display("FAIL reset_flags: got %b want 100", {ready, busy, done});
        end
        cmpCount++;
        if (product !== 8'h00) begin
            errCount++;
            $display("FAIL reset_product: got %h want 00", product);
        end
`ifdef MUL_ZERO_FLAG_EN
        cmpCount++;
        if (zero !== 1'b1) begin
            errCount++;
            $display("FAIL reset_zero: got %b want 1", zero);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic checkOp(
        input string          name,
        input logic [W-1:0]   ai,
        input logic [W-1:0]   bi,
        input bit             holdStart,
        input logic [2*W-1:0] want
    );
        int             lat;
        bit             busyBad;
        bit             tmo;
        int             dc;
        logic [2*W-1:0] pStale;
        logic [2*W-1:0] p;
        logic [2*W-1:0] prevProd;
        logic           z;
        prevProd = product;
        runOp(ai, bi, holdStart, lat, busyBad, pStale, p, z, dc, tmo);
        cmpCount++;
        if (tmo) begin
            errCount++;
            $display("FAIL %s_timeout: no done after %0d cycles", name, lat);
            return;
        end
        cmpCount++;
        if (p !== want) begin
            errCount++;
            $display("FAIL %s_product: got %h want %h", name, p, want);
        end
        cmpCount++;
        if (lat != LAT || busyBad) begin
            errCount++;
            $display("FAIL %s_latency: got %0d busyBad=%0b want %0d",
                     name, lat, busyBad, LAT);
        end
        cmpCount++;
        if (pStale !== prevProd) begin
            errCount++;
            $display("FAIL %s_stale: got %h want %h", name, pStale, prevProd);
        end
`ifdef MUL_ZERO_FLAG_EN
        cmpCount++;
        if (z !== (want == 0)) begin
            errCount++;
            $display("FAIL %s_zero: got %b want %b", name, z, want == 0);
        end
`endif
        @(negedge clk);
        cmpCount++;
        if ({ready, busy, done} !== 3'b100) begin
            errCount++;
            $display("FAIL %s_after: flags %b want 100", name,
                     {ready, busy, done});
        end
    endtask

    task automatic test_basic();
        checkOp("basic_c_x_1", 4'hC, 4'h1, 1'b0, 8'h0C);
    endtask

    task automatic test_carry();
        checkOp("carry_f_x_f", 4'hF, 4'hF, 1'b0, 8'hE1);
    endtask

    task automatic test_zero();
        checkOp("zero_0_x_9", 4'h0, 4'h9, 1'b0, 8'h00);
        checkOp("zero_3_x_5", 4'h3, 4'h5, 1'b0, 8'h0F);
    endtask

    task automatic test_hold_start();
        checkOp("hold_6_x_7", 4'h6, 4'h7, 1'b1, 8'h2A);
    endtask

    task automatic test_reset_midrun();
        bit sawDone;
        a     = 4'h9;
        b     = 4'h9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        cmpCount++;
        if (busy !== 1'b1) begin
            errCount++;
            $display("FAIL midrun_busy: got %b want 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cmpCount++;
        if ({ready, busy, done} !== 3'b100 || product !== 8'h00) begin
            errCount++;
            $display("FAIL midrun_reset: flags %b prod %h want 100 00",
                     {ready, busy, done}, product);
        end
        sawDone = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done) sawDone = 1'b1;
            @(negedge clk);
        end
        cmpCount++;
        if (sawDone) begin
            errCount++;
            $display("FAIL midrun_nodone: got done=1 want 0");
        end
        checkOp("midrun_9_x_9", 4'h9, 4'h9, 1'b0, 8'h51);
    endtask

    task automatic test_rst_start();
        rst   = 1'b1;
        start = 1'b1;
        a     = 4'h5;
        b     = 4'h5;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        cmpCount++;
        if ({ready, busy} !== 2'b10) begin
            errCount++;
            $display("FAIL rst_start_1: flags %b want 10", {ready, busy});
        end
        @(negedge clk);
        cmpCount++;
        if ({ready, busy} !== 2'b10) begin
            errCount++;
            $display("FAIL rst_start_2: flags %b want 10", {ready, busy});
        end
    endtask

    task automatic test_back_to_back();
        int             lat1, lat2, dc1, dc2;
        bit             bb1, bb2, t1, t2;
        logic [2*W-1:0] s1, s2, p1, p2;
        logic           z1, z2;
        runOp(4'h2, 4'h3, 1'b0, lat1, bb1, s1, p1, z1, dc1, t1);
        runOp(4'h7, 4'h4, 1'b0, lat2, bb2, s2, p2, z2, dc2, t2);
        cmpCount++;
        if (t1 || p1 !== 8'h06) begin
            errCount++;
            $display("FAIL b2b_first: got %h tmo=%0b want 06", p1, t1);
        end
        cmpCount++;
        if (t2 || p2 !== 8'h1C) begin
            errCount++;
            $display("FAIL b2b_second: got %h tmo=%0b want 1c", p2, t2);
        end
        cmpCount++;
        if (dc2 - dc1 != LAT + 1) begin
            errCount++;
            $display("FAIL b2b_spacing: got %0d want %0d", dc2 - dc1, LAT + 1);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;
        logic [2*W-1:0] want;
        for (int i = 0; i < 24; i++) begin
            ra   = W'($urandom_range(0, (1 << W) - 1));
            rb   = W'($urandom_range(0, (1 << W) - 1));
            want = (2*W)'(int'(ra) * int'(rb));
            checkOp("random", ra, rb, 1'($urandom_range(0, 1)), want);
        end
    endtask

    initial begin
        cmpCount = 0;
        errCount = 0;
        test_reset();
        test_basic();
        test_carry();
        test_zero();
        test_hold_start();
        test_reset_midrun();
        test_rst_start();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 cmpCount, errCount);
        $finish;
    end

endmodule
